// File: rtl/encoder_2to4bits_tx_if.sv
// ---------------------------------------------------------------------------
// encoder_2to4bits_tx_if
// Symbol ingress handshake for encoder_2to4bits_tx.
//   in_valid : producer offers in_sym this cycle
//   in_sym   : 2-bit symbol {Y0,Y1}
//   in_ready : encoder FIFO can take a symbol this cycle
// master = symbol producer, slave = encoder.
// ---------------------------------------------------------------------------
interface encoder_2to4bits_tx_if;
    logic       in_valid;
    logic [1:0] in_sym;
    logic       in_ready;

    modport master (
        output in_valid,
        output in_sym,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_sym,
        output in_ready
    );
endinterface

// File: rtl/encoder_2to4bits_tx.sv
// ---------------------------------------------------------------------------
// encoder_2to4bits_tx
// Queues 2-bit symbols in a small FIFO, maps each to a fixed 4-bit codeword
// and shifts the codeword out serially (A first, D last), with an optional
// idle gap between frames.
//
// Ports
//   clk        : system clock, all state on the rising edge
//   rst_n      : asynchronous active-low reset
//   in_if      : symbol handshake (in_valid, in_sym, in_ready)
//   tx_bit     : serial codeword bit
//   tx_frame   : high on each of the 4 bit cycles of a frame
//   tx_sof     : high on bit A only
//   code_last  : last codeword {A,B,C,D} loaded for transmission
//   fifo_level : current FIFO occupancy
//   sent_count : completed frames, modulo 256
//   busy       : state is not IDLE
//
// FSM states
//   state    | meaning
//   IDLE     | waiting for a queued symbol; pops it when present
//   SHIFT    | sending codeword bit idx_q (0=A .. 3=D)
//   GAP      | inter-frame idle, gap_q counts down to 0
// ---------------------------------------------------------------------------
module encoder_2to4bits_tx #(
    parameter int FIFO_DEPTH = 4,
    parameter int IDLE_GAP   = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    encoder_2to4bits_tx_if.slave        in_if,
    output logic                        tx_bit,
    output logic                        tx_frame,
    output logic                        tx_sof,
    output logic [3:0]                  code_last,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [7:0]                  sent_count,
    output logic                        busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int GAP_W = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;

    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
    // GAP is held for IDLE_GAP cycles, so the down-counter starts at IDLE_GAP-1.
    localparam logic [GAP_W-1:0] GAP_LOAD = (IDLE_GAP > 0) ? GAP_W'(IDLE_GAP - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    function automatic logic [3:0] encode(input logic [1:0] sym);
        logic [3:0] word;
        case (sym)
            2'b00:   word = 4'b0110;
            2'b01:   word = 4'b0000;
            2'b10:   word = 4'b0100;
            default: word = 4'b0010;
        endcase
        return word;
    endfunction

    // -----------------------------------------------------------------------
    // Symbol FIFO
    // -----------------------------------------------------------------------
    logic [1:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             push;
    logic             pop;
    logic             fifo_ne;
    logic [1:0]       head_sym;

    // in_ready depends on occupancy only, so a full FIFO refuses input even
    // on an edge where the FSM pops.
    assign in_if.in_ready = (level_q != FULL_LVL);
    assign push           = in_if.in_valid && in_if.in_ready;
    assign fifo_ne        = (level_q != '0);
    assign head_sym       = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_if.in_sym;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // -----------------------------------------------------------------------
    // Frame FSM
    // -----------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [3:0]       code_q, code_d;
    logic [7:0]       sent_q, sent_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        code_d  = code_q;
        sent_d  = sent_q;
        pop     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (fifo_ne) begin
                    pop     = 1'b1;
                    code_d  = encode(head_sym);
                    idx_d   = 2'd0;
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (idx_q == 2'd3) begin
                    sent_d = sent_q + 8'd1;
                    if (IDLE_GAP > 0) begin
                        gap_d   = GAP_LOAD;
                        state_d = ST_GAP;
                    end else if (fifo_ne) begin
                        // Zero-gap mode: chain straight into the next frame.
                        pop     = 1'b1;
                        code_d  = encode(head_sym);
                        idx_d   = 2'd0;
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end

            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - GAP_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
            gap_q   <= '0;
            code_q  <= 4'b0000;
            sent_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            code_q  <= code_d;
            sent_q  <= sent_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: decoded purely from flops, so the serial pins carry no
    // combinational path from the input handshake and clear with the async
    // reset.
    // -----------------------------------------------------------------------
    assign tx_frame   = (state_q == ST_SHIFT);
    assign tx_bit     = tx_frame && code_q[2'd3 - idx_q];
    assign tx_sof     = tx_frame && (idx_q == 2'd0);
    assign code_last  = code_q;
    assign fifo_level = level_q;
    assign sent_count = sent_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_encoder_2to4bits_tx.sv
// ---------------------------------------------------------------------------
// tb_encoder_2to4bits_tx
// Directed bench for encoder_2to4bits_tx. dut_g uses IDLE_GAP=1, dut_z uses
// IDLE_GAP=0; both FIFO_DEPTH=4 and share clock and reset.
// Expected serial streams are written as strings: '_' = no frame, '0'/'1' =
// frame bit; tx_sof is expected on every 4th bit of a run of frame bits.
// ---------------------------------------------------------------------------
module tb_encoder_2to4bits_tx;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    encoder_2to4bits_tx_if ifg ();
    encoder_2to4bits_tx_if ifz ();

    logic       g_bit, g_frame, g_sof, g_busy;
    logic [3:0] g_code;
    logic [2:0] g_level;
    logic [7:0] g_sent;
    logic       z_bit, z_frame, z_sof, z_busy;
    logic [3:0] z_code;
    logic [2:0] z_level;
    logic [7:0] z_sent;

    encoder_2to4bits_tx #(.FIFO_DEPTH(4), .IDLE_GAP(1)) dut_g (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_if      (ifg),
        .tx_bit     (g_bit),
        .tx_frame   (g_frame),
        .tx_sof     (g_sof),
        .code_last  (g_code),
        .fifo_level (g_level),
        .sent_count (g_sent),
        .busy       (g_busy)
    );

    encoder_2to4bits_tx #(.FIFO_DEPTH(4), .IDLE_GAP(0)) dut_z (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_if      (ifz),
        .tx_bit     (z_bit),
        .tx_frame   (z_frame),
        .tx_sof     (z_sof),
        .code_last  (z_code),
        .fifo_level (z_level),
        .sent_count (z_sent),
        .busy       (z_busy)
    );

    int errors = 0;
    int checks = 0;

    logic       drv_v [64];
    logic [1:0] drv_s [64];
    logic       cap_f [64];
    logic       cap_b [64];
    logic       cap_s [64];
    logic       cap_r [64];
    logic [2:0] cap_l [64];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_drv();
        for (int i = 0; i < 64; i++) begin
            drv_v[i] = 1'b0;
            drv_s[i] = 2'b00;
        end
    endtask

    task automatic do_reset();
        ifg.in_valid = 1'b0;
        ifg.in_sym   = 2'b00;
        ifz.in_valid = 1'b0;
        ifz.in_sym   = 2'b00;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Drives drv_* for n cycles into one DUT and records its outputs after
    // each edge; in_ready is recorded before the edge it qualifies.
    task automatic capture(input int n, input bit use_z);
        for (int i = 0; i < n; i++) begin
            if (use_z) begin
                ifz.in_valid = drv_v[i];
                ifz.in_sym   = drv_s[i];
                cap_r[i]     = ifz.in_ready;
            end else begin
                ifg.in_valid = drv_v[i];
                ifg.in_sym   = drv_s[i];
                cap_r[i]     = ifg.in_ready;
            end
            tick();
            cap_f[i] = use_z ? z_frame : g_frame;
            cap_b[i] = use_z ? z_bit   : g_bit;
            cap_s[i] = use_z ? z_sof   : g_sof;
            cap_l[i] = use_z ? z_level : g_level;
        end
        ifg.in_valid = 1'b0;
        ifz.in_valid = 1'b0;
    endtask

    // Expected {frame, bit, sof} at position i of a stream string.
    function automatic logic [2:0] exp_at(input string s, input int i);
        int   k = 0;
        logic f;
        logic b;
        f = (s[i] != "_");
        b = (s[i] == "1");
        for (int j = i - 1; j >= 0 && s[j] != "_"; j--) k++;
        return {f, b, f && (k % 4 == 0)};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        ifg.in_valid = 1'b1;
        ifg.in_sym   = 2'b01;
        tick();
        tick();
        checks++;
        if ({g_bit, g_frame, g_sof, g_busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_serial: bit/frame/sof/busy=%b want 0000", {g_bit, g_frame, g_sof, g_busy});
        end
        checks++;
        if (g_code !== 4'b0000 || g_level !== 3'd0 || g_sent !== 8'd0) begin
            errors++;
            $display("FAIL reset_regs: code=%b level=%0d sent=%0d want 0000 0 0", g_code, g_level, g_sent);
        end
        checks++;
        if (ifg.in_ready !== 1'b1 || ifz.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: g=%b z=%b want 1 1", ifg.in_ready, ifz.in_ready);
        end
        do_reset();
        checks++;
        if (ifg.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %b want 1", ifg.in_ready);
        end
    endtask

    task automatic test_single();
        string      exp = "_0100___";
        logic [2:0] e;
        do_reset();
        clear_drv();
        drv_v[0] = 1'b1;
        drv_s[0] = 2'b10;
        capture(exp.len(), 1'b0);
        checks++;
        if (cap_l[0] !== 3'd1) begin
            errors++;
            $display("FAIL first_edge_push: level=%0d want 1", cap_l[0]);
        end
        for (int i = 0; i < exp.len(); i++) begin
            e = exp_at(exp, i);
            checks++;
            if ({cap_f[i], cap_b[i], cap_s[i]} !== e) begin
                errors++;
                $display("FAIL single_stream cycle %0d: frame/bit/sof=%b want %b", i, {cap_f[i], cap_b[i], cap_s[i]}, e);
            end
        end
        checks++;
        if (g_code !== 4'b0100 || g_sent !== 8'd1 || g_busy !== 1'b0) begin
            errors++;
            $display("FAIL single_end: code=%b sent=%0d busy=%b want 0100 1 0", g_code, g_sent, g_busy);
        end
    endtask

    task automatic test_back_to_back();
        string      exp = "_0110__0000__0100__0010___";
        logic [2:0] e;
        do_reset();
        clear_drv();
        for (int i = 0; i < 4; i++) begin
            drv_v[i] = 1'b1;
            drv_s[i] = 2'(i);
        end
        capture(exp.len(), 1'b0);
        for (int i = 0; i < exp.len(); i++) begin
            e = exp_at(exp, i);
            checks++;
            if ({cap_f[i], cap_b[i], cap_s[i]} !== e) begin
                errors++;
                $display("FAIL b2b_stream cycle %0d: frame/bit/sof=%b want %b", i, {cap_f[i], cap_b[i], cap_s[i]}, e);
            end
        end
        checks++;
        if (g_sent !== 8'd4 || g_level !== 3'd0) begin
            errors++;
            $display("FAIL b2b_end: sent=%0d level=%0d want 4 0", g_sent, g_level);
        end
    endtask

    task automatic test_fifo_full();
        string      exp = "_0010__0110__0000__0100__0010____";
        logic [1:0] syms [6];
        logic       rdy_exp [6];
        logic [2:0] e;
        syms = '{2'b11, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
        rdy_exp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        do_reset();
        clear_drv();
        for (int i = 0; i < 6; i++) begin
            drv_v[i] = 1'b1;
            drv_s[i] = syms[i];
        end
        capture(exp.len(), 1'b0);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (cap_r[i] !== rdy_exp[i]) begin
                errors++;
                $display("FAIL full_ready cycle %0d: in_ready=%b want %b", i, cap_r[i], rdy_exp[i]);
            end
        end
        checks++;
        if (cap_l[4] !== 3'd4 || cap_l[5] !== 3'd4) begin
            errors++;
            $display("FAIL full_level: level=%0d,%0d want 4,4", cap_l[4], cap_l[5]);
        end
        for (int i = 0; i < exp.len(); i++) begin
            e = exp_at(exp, i);
            checks++;
            if ({cap_f[i], cap_b[i], cap_s[i]} !== e) begin
                errors++;
                $display("FAIL full_stream cycle %0d: frame/bit/sof=%b want %b", i, {cap_f[i], cap_b[i], cap_s[i]}, e);
            end
        end
        checks++;
        if (g_sent !== 8'd5 || g_level !== 3'd0) begin
            errors++;
            $display("FAIL full_end: sent=%0d level=%0d want 5 0", g_sent, g_level);
        end
    endtask

    task automatic test_no_gap();
        string      exp = "_000001000110___";
        logic [2:0] e;
        do_reset();
        clear_drv();
        drv_v[0] = 1'b1; drv_s[0] = 2'b01;
        drv_v[1] = 1'b1; drv_s[1] = 2'b10;
        drv_v[2] = 1'b1; drv_s[2] = 2'b00;
        capture(exp.len(), 1'b1);
        for (int i = 0; i < exp.len(); i++) begin
            e = exp_at(exp, i);
            checks++;
            if ({cap_f[i], cap_b[i], cap_s[i]} !== e) begin
                errors++;
                $display("FAIL nogap_stream cycle %0d: frame/bit/sof=%b want %b", i, {cap_f[i], cap_b[i], cap_s[i]}, e);
            end
        end
        checks++;
        if (z_sent !== 8'd3 || z_busy !== 1'b0 || z_code !== 4'b0110) begin
            errors++;
            $display("FAIL nogap_end: sent=%0d busy=%b code=%b want 3 0 0110", z_sent, z_busy, z_code);
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        ifg.in_valid = 1'b1;
        ifg.in_sym   = 2'b00;
        tick();
        ifg.in_sym   = 2'b11;
        tick();
        ifg.in_valid = 1'b0;
        tick();
        tick();
        checks++;
        if ({g_frame, g_bit, g_sof, g_level} !== {3'b110, 3'd1}) begin
            errors++;
            $display("FAIL midframe_pre: frame/bit/sof=%b level=%0d want 110 1", {g_frame, g_bit, g_sof}, g_level);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({g_bit, g_frame, g_sof, g_busy} !== 4'b0000) begin
            errors++;
            $display("FAIL midframe_async: bit/frame/sof/busy=%b want 0000", {g_bit, g_frame, g_sof, g_busy});
        end
        checks++;
        if (g_code !== 4'b0000 || g_level !== 3'd0 || g_sent !== 8'd0 || ifg.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midframe_regs: code=%b level=%0d sent=%0d ready=%b want 0000 0 0 1", g_code, g_level, g_sent, ifg.in_ready);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (g_frame !== 1'b0 || g_busy !== 1'b0) begin
                errors++;
                $display("FAIL midframe_residual cycle %0d: frame=%b busy=%b want 0 0", i, g_frame, g_busy);
            end
        end
        checks++;
        if (g_sent !== 8'd0) begin
            errors++;
            $display("FAIL midframe_count: sent=%0d want 0", g_sent);
        end
    endtask

    task automatic test_wrap();
        int   accepted = 0;
        int   sofs = 0;
        int   cycles = 0;
        logic rdy;
        do_reset();
        while ((accepted < 257 || z_busy || z_level != 3'd0) && cycles < 3000) begin
            ifz.in_valid = (accepted < 257);
            ifz.in_sym   = accepted[1:0];
            rdy = ifz.in_ready;
            tick();
            if (ifz.in_valid && rdy) accepted++;
            if (z_sof) sofs++;
            cycles++;
        end
        ifz.in_valid = 1'b0;
        checks++;
        if (cycles >= 3000) begin
            errors++;
            $display("FAIL wrap_timeout: cycles=%0d want < 3000", cycles);
        end
        checks++;
        if (sofs !== 257) begin
            errors++;
            $display("FAIL wrap_frames: sof pulses=%0d want 257", sofs);
        end
        checks++;
        if (z_sent !== 8'd1) begin
            errors++;
            $display("FAIL wrap_count: sent=%0d want 1", z_sent);
        end
    endtask

    initial begin
        ifg.in_valid = 1'b0;
        ifg.in_sym   = 2'b00;
        ifz.in_valid = 1'b0;
        ifz.in_sym   = 2'b00;
        test_reset();
        test_single();
        test_back_to_back();
        test_fifo_full();
        test_no_gap();
        test_reset_mid_frame();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule

// File: doc/encoder_2to4bits_tx.md
ENCODER_2TO4BITS_TX -- requirements
Module: encoder_2to4bits_tx

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, the symbol FIFO depth (power of two, >= 2).
REQ-002 The block SHALL have parameter IDLE_GAP, default 1, the number of idle cycles inserted between frames (0 = back-to-back).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state on rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, the asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit, meaning in_sym is offered.
REQ-006 The block SHALL have port in_sym, input, 2 bits, the symbol {Y0,Y1} (bit1 = Y0, bit0 = Y1).
REQ-007 The block SHALL have port in_ready, output, 1 bit, meaning the FIFO can accept a symbol this cycle.
REQ-008 The block SHALL have port tx_bit, output, 1 bit, the serial codeword bit, sent in order A, B, C, D.
REQ-009 The block SHALL have port tx_frame, output, 1 bit, high during each of the 4 bit cycles of a frame.
REQ-010 The block SHALL have port tx_sof, output, 1 bit, high only on the first bit (A) of a frame.
REQ-011 The block SHALL have port code_last, output, 4 bits, the last codeword {A,B,C,D} loaded for transmission.
REQ-012 The block SHALL have port fifo_level, output, clog2(FIFO_DEPTH)+1 bits, the current FIFO occupancy.
REQ-013 The block SHALL have port sent_count, output, 8 bits, the number of completed frames modulo 256.
REQ-014 The block SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.

Function
REQ-015 Encoding SHALL be fixed as: sym 00 -> ABCD 0110; 01 -> 0000; 10 -> 0100; 11 -> 0010. Each codeword decodes back to its symbol via Y1 = B xnor D and the team's 4-to-2 Y0 equation.
REQ-016 A push SHALL occur on a rising edge where in_valid && in_ready; in_ready SHALL equal (fifo_level != FIFO_DEPTH), combinationally.
REQ-017 With the FIFO full, in_valid SHALL be ignored: no push, no overwrite, no bypass.
REQ-018 A push and a pop on the same edge SHALL leave fifo_level unchanged and preserve FIFO order.
REQ-019 The FSM SHALL have the states IDLE, SHIFT (bit index 0..3) and GAP (down-counter).
REQ-020 IDLE SHALL behave as follows: when the FIFO is non-empty, pop on that edge, load the shift register with the encoded word, set code_last, and enter SHIFT with bit index 0.
REQ-021 SHIFT SHALL be registered: tx_frame=1, tx_bit = codeword bit at index (0=A ... 3=D), and tx_sof=1 only at index 0. The first bit appears the cycle after the pop edge, giving 1-cycle latency from pop.
REQ-022 At the edge ending index 3, sent_count SHALL increment, wrapping 255 -> 0.
REQ-023 At that same edge, the next state SHALL be GAP when IDLE_GAP > 0; when IDLE_GAP = 0 and the FIFO is non-empty, pop and restart SHIFT at index 0 with no dead cycle; otherwise IDLE.
REQ-024 GAP SHALL hold tx_frame=tx_sof=tx_bit=0 for exactly IDLE_GAP cycles, then return to IDLE. A waiting symbol SHALL then be popped in that IDLE cycle, so the spacing between frames is IDLE_GAP+1 cycles.
REQ-025 Outside SHIFT, tx_bit, tx_frame and tx_sof SHALL be 0.
REQ-026 A push during SHIFT or GAP SHALL be accepted normally and SHALL NOT disturb the frame in flight.
REQ-027 FIFO pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-028 rst_n low SHALL, immediately and asynchronously, force state IDLE, empty the FIFO (fifo_level=0), and clear tx_bit, tx_frame, tx_sof, code_last=0000, sent_count=0 and busy=0.
REQ-029 in_ready SHALL read 1 during and after reset.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no completion count.
REQ-031 The first edge after rst_n rises SHALL accept a push.

Verification
REQ-032 Reset then push sym 10 once -> after 1 cycle in IDLE, frame tx_bit 0,1,0,0 with tx_sof on the first bit only; code_last=0100; sent_count=1.
REQ-033 Push 00, 01, 10, 11 back-to-back with IDLE_GAP=1 -> serial stream 0110, gap, 0000, gap, 0100, gap, 0010; sent_count=4; fifo_level returns to 0.
REQ-034 Push 6 symbols continuously while the first frame is shifting, FIFO_DEPTH=4 -> in_ready deasserts at level 4, the extra push is dropped, and only the accepted symbols are sent in order.
REQ-035 IDLE_GAP=0 with 3 queued symbols -> 12 consecutive tx_frame=1 cycles with tx_sof every 4th cycle.
REQ-036 Assert rst_n low at bit index 2 of a frame -> all outputs 0 within the same cycle, sent_count=0, and no residual frame after release.
REQ-037 Send 257 frames -> sent_count reads 1 (wrap verified).
